// File: rtl/axi_mem_pkg.sv
// rtl/axi_mem_pkg.sv - shared response codes, FSM state enums and range helper for the AXI memory slave
package axi_mem_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_t;

    function automatic logic in_range(input logic [63:0] addr, input int unsigned size);
        return addr < 64'(size);
    endfunction

endpackage

// File: rtl/axi_mem_rd_port.sv
// rtl/axi_mem_rd_port.sv - one independent read channel: AR handshake then an incrementing R burst
module axi_mem_rd_port
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 1024,
    parameter int IDX_W      = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    output logic                  rlast,
    input  logic                  rready,
    output logic [IDX_W-1:0]      mem_idx,
    input  logic [DATA_WIDTH-1:0] mem_word
);

    rd_state_t             state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [7:0]            cnt;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  next_ok;

    // Lookup address is the incoming araddr while idle, else the beat after the one on the bus.
    assign next_addr = (state == R_IDLE) ? araddr : addr + ADDR_WIDTH'(1);
    assign next_ok   = in_range(64'(next_addr), MEM_SIZE);
    assign mem_idx   = next_addr[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rresp   <= OKAY;
            rdata   <= '0;
            addr    <= '0;
            len     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        addr    <= araddr;
                        len     <= arlen;
                        cnt     <= '0;
                        rdata   <= next_ok ? mem_word : '0;
                        rresp   <= next_ok ? OKAY : SLVERR;
                        rvalid  <= 1'b1;
                        rlast   <= (arlen == 8'd0);
                        arready <= 1'b0;
                        state   <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (rvalid && rready) begin
                        if (cnt == len) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            rdata   <= '0;
                            rresp   <= OKAY;
                            arready <= 1'b1;
                            state   <= R_IDLE;
                        end else begin
                            addr  <= next_addr;
                            cnt   <= cnt + 8'd1;
                            rdata <= next_ok ? mem_word : '0;
                            rresp <= next_ok ? OKAY : SLVERR;
                            rlast <= ((cnt + 8'd1) == len);
                        end
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi_mem_slave_nrd.sv
// rtl/axi_mem_slave_nrd.sv - AXI memory slave, one write port and NUM_RD read ports; AXI_MEM_WSTRB_EN adds wstrb
module axi_mem_slave_nrd
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_RD      = 2,
    parameter int MEM_SIZE    = 1024,
    parameter int INIT_OPTION = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [ADDR_WIDTH-1:0]              awaddr,
    input  logic [7:0]                         awlen,
    input  logic                               awvalid,
    output logic                               awready,
    input  logic [DATA_WIDTH-1:0]              wdata,
    input  logic                               wvalid,
    input  logic                               wlast,
`ifdef AXI_MEM_WSTRB_EN
    input  logic [DATA_WIDTH/8-1:0]            wstrb,
`endif
    output logic                               wready,
    output logic [1:0]                         bresp,
    output logic                               bvalid,
    input  logic                               bready,
    input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]  araddr,
    input  logic [NUM_RD-1:0][7:0]             arlen,
    input  logic [NUM_RD-1:0]                  arvalid,
    output logic [NUM_RD-1:0]                  arready,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]  rdata,
    output logic [NUM_RD-1:0][1:0]             rresp,
    output logic [NUM_RD-1:0]                  rvalid,
    output logic [NUM_RD-1:0]                  rlast,
    input  logic [NUM_RD-1:0]                  rready
);

    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
    logic                  init_done;

    wr_state_t             w_state;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [7:0]            w_cnt;
    logic                  w_err;
    logic                  w_beat;
    logic                  w_ok;
    logic                  w_final;
    logic                  w_beat_err;

    assign w_beat     = (w_state == W_DATA) && wvalid && wready;
    assign w_ok       = in_range(64'(w_addr), MEM_SIZE);
    assign w_final    = (w_cnt == w_len);
    assign w_beat_err = (wlast != w_final) || !w_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        w_addr  <= awaddr;
                        w_len   <= awlen;
                        w_cnt   <= '0;
                        w_err   <= 1'b0;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        w_addr <= w_addr + ADDR_WIDTH'(1);
                        w_cnt  <= w_cnt + 8'd1;
                        w_err  <= w_err || w_beat_err;
                        if (w_final) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bresp   <= (w_err || w_beat_err) ? SLVERR : OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        bresp   <= OKAY;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Power-up fill happens on the very first clock edge; reset never touches the array afterwards.
    always_ff @(posedge clk) begin
        init_done <= 1'b1;
        if (!init_done) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem[i] <= (INIT_OPTION == 1) ? DATA_WIDTH'(i) : '0;
            end
        end else if (w_beat && w_ok) begin
`ifdef AXI_MEM_WSTRB_EN
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb[b]) begin
                    mem[w_addr[IDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
`else
            mem[w_addr[IDX_W-1:0]] <= wdata;
`endif
        end
    end

    logic [IDX_W-1:0]      rd_idx  [NUM_RD];
    logic [DATA_WIDTH-1:0] rd_word [NUM_RD];

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        assign rd_word[g] = mem[rd_idx[g]];

        axi_mem_rd_port #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .MEM_SIZE   (MEM_SIZE),
            .IDX_W      (IDX_W)
        ) u_rd (
            .clk      (clk),
            .rst_n    (rst_n),
            .araddr   (araddr[g]),
            .arlen    (arlen[g]),
            .arvalid  (arvalid[g]),
            .arready  (arready[g]),
            .rdata    (rdata[g]),
            .rresp    (rresp[g]),
            .rvalid   (rvalid[g]),
            .rlast    (rlast[g]),
            .rready   (rready[g]),
            .mem_idx  (rd_idx[g]),
            .mem_word (rd_word[g])
        );
    end

endmodule

// File: tb/tb_axi_mem_slave_nrd.sv
// tb/tb_axi_mem_slave_nrd.sv - directed self-checking bench for axi_mem_slave_nrd
module tb_axi_mem_slave_nrd;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       awaddr;
    logic [7:0]        awlen;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic              wvalid;
    logic              wlast;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [1:0][31:0]  araddr;
    logic [1:0][7:0]   arlen;
    logic [1:0]        arvalid;
    logic [1:0]        arready;
    logic [1:0][31:0]  rdata;
    logic [1:0][1:0]   rresp;
    logic [1:0]        rvalid;
    logic [1:0]        rlast;
    logic [1:0]        rready;
    logic [3:0]        wstrb_v;

    logic [31:0]       model [1024];
    int                n_cmp  = 0;
    int                n_fail = 0;

    always #5 clk = ~clk;

    axi_mem_slave_nrd #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .NUM_RD      (2),
        .MEM_SIZE    (1024),
        .INIT_OPTION (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wvalid  (wvalid),
        .wlast   (wlast),
`ifdef AXI_MEM_WSTRB_EN
        .wstrb   (wstrb_v),
`endif
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arlen   (arlen),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rlast   (rlast),
        .rready  (rready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input int a);
        return (a < 1024) ? model[a] : 32'h0;
    endfunction

    function automatic logic [1:0] exp_resp(input int a);
        return (a < 1024) ? 2'b00 : 2'b10;
    endfunction

    task automatic wr_burst(input int addr, input int len, input int seed, input int delta,
                            input int last_at, input logic [1:0] resp);
        logic [31:0] d;
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{wstrb_v[b]}};
        awaddr  = 32'(addr);
        awlen   = 8'(len);
        awvalid = 1'b1;
        chk("awready_idle", awready, 1'b1);
        step();
        awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            d      = 32'(seed + k * delta);
            wdata  = d;
            wvalid = 1'b1;
            wlast  = (k == last_at);
            chk("wready_beat", wready, 1'b1);
            if (addr + k < 1024) model[addr + k] = (model[addr + k] & ~mask) | (d & mask);
            step();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        chk("bvalid_set", bvalid, 1'b1);
        chk("bresp", bresp, resp);
        step();
        chk("bvalid_hold", bvalid, 1'b1);
        chk("bresp_hold", bresp, resp);
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("bvalid_clr", bvalid, 1'b0);
        chk("awready_back", awready, 1'b1);
    endtask

    // Channels 0..nch-1 issue AR together and share one rready pattern.
    task automatic rd_burst(input int nch, input int a0, input int a1, input int len, input bit toggle);
        int   a [2];
        int   beat = 0;
        int   cyc  = 0;
        logic rr;
        a[0] = a0;
        a[1] = a1;
        for (int c = 0; c < nch; c++) begin
            araddr[c]  = 32'(a[c]);
            arlen[c]   = 8'(len);
            arvalid[c] = 1'b1;
            chk("arready_idle", arready[c], 1'b1);
        end
        step();
        for (int c = 0; c < nch; c++) arvalid[c] = 1'b0;
        while (beat <= len && cyc < 64) begin
            rr = toggle ? ((cyc % 2) == 0) : 1'b1;
            for (int c = 0; c < nch; c++) begin
                rready[c] = rr;
                chk("rvalid", rvalid[c], 1'b1);
                chk("rdata", rdata[c], exp_data(a[c] + beat));
                chk("rlast", rlast[c], (beat == len));
                chk("rresp", rresp[c], exp_resp(a[c] + beat));
            end
            step();
            if (rr) beat++;
            cyc++;
        end
        chk("rd_beats_done", 64'(beat), 64'(len + 1));
        for (int c = 0; c < nch; c++) begin
            rready[c] = 1'b0;
            chk("rvalid_end", rvalid[c], 1'b0);
            chk("rlast_end", rlast[c], 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = 32'(i);
        rst_n   = 1'b0;
        awaddr  = '0;
        awlen   = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wvalid  = 1'b0;
        wlast   = 1'b0;
        bready  = 1'b0;
        araddr  = '0;
        arlen   = '0;
        arvalid = '0;
        rready  = '0;
        wstrb_v = 4'hF;

        step();
        step();
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_arready", arready, 2'b00);
        chk("rst_rvalid", rvalid, 2'b00);
        chk("rst_rlast", rlast, 2'b00);
        chk("rst_rresp", rresp, 4'h0);
        chk("rst_rdata", rdata, 64'h0);
        rst_n = 1'b1;
        step();
        chk("post_rst_awready", awready, 1'b1);
        chk("post_rst_arready", arready, 2'b11);

        rd_burst(1, 10, 0, 3, 1'b0);

        wr_burst(100, 1, 32'hA5, -32'sh4B, 1, 2'b00);
        rd_burst(1, 100, 0, 1, 1'b0);

        rd_burst(2, 0, 500, 7, 1'b1);

        wr_burst(1022, 3, 32'h11, 32'h11, 3, 2'b10);
        rd_burst(1, 1023, 0, 1, 1'b0);
        rd_burst(2, 1021, 1022, 2, 1'b0);

        wr_burst(200, 1, 32'h1000, 32'h1, 0, 2'b10);
        rd_burst(1, 200, 0, 1, 1'b0);

        awaddr  = 32'd300;
        awlen   = 8'd0;
        awvalid = 1'b1;
        step();
        awvalid    = 1'b0;
        wdata      = 32'hDEAD0300;
        wvalid     = 1'b1;
        wlast      = 1'b1;
        araddr[1]  = 32'd300;
        arlen[1]   = 8'd0;
        arvalid[1] = 1'b1;
        chk("coll_arready", arready[1], 1'b1);
        step();
        wvalid     = 1'b0;
        wlast      = 1'b0;
        arvalid[1] = 1'b0;
        chk("coll_old_data", rdata[1], 32'd300);
        chk("coll_rlast_len0", rlast[1], 1'b1);
        chk("coll_bvalid", bvalid, 1'b1);
        chk("coll_bresp", bresp, 2'b00);
        model[300] = 32'hDEAD0300;
        rready[1]  = 1'b1;
        bready     = 1'b1;
        step();
        rready[1] = 1'b0;
        bready    = 1'b0;
        chk("coll_rvalid_clr", rvalid[1], 1'b0);
        chk("coll_bvalid_clr", bvalid, 1'b0);
        rd_burst(1, 300, 0, 0, 1'b0);

        araddr[0]  = 32'd0;
        arlen[0]   = 8'd7;
        arvalid[0] = 1'b1;
        rready[0]  = 1'b1;
        step();
        arvalid[0] = 1'b0;
        step();
        step();
        chk("mid_beat2_rdata", rdata[0], 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", rvalid[0], 1'b0);
        chk("mid_rst_rlast", rlast[0], 1'b0);
        chk("mid_rst_arready", arready, 2'b00);
        step();
        rst_n     = 1'b1;
        rready[0] = 1'b0;
        step();
        chk("rel_arready", arready, 2'b11);
        chk("rel_awready", awready, 1'b1);
        chk("rel_rvalid", rvalid, 2'b00);
        chk("rel_bvalid", bvalid, 1'b0);
        rd_burst(1, 100, 0, 1, 1'b0);

`ifdef AXI_MEM_WSTRB_EN
        wr_burst(400, 0, 0, 0, 0, 2'b00);
        wstrb_v = 4'b0001;
        wr_burst(400, 0, 32'hFFFFFFFF, 0, 0, 2'b00);
        wstrb_v = 4'hF;
        chk("strb_model", model[400], 32'h000000FF);
        rd_burst(1, 400, 0, 0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
